// File: rtl/sorted_stream_out.sv
// ---------------------------------------------------------------------------
// sorted_stream_out
//
// Takes one complete sorted frame of distance values from the sorter and
// streams the nearest num_req of them out one value per beat over a
// valid/ready handshake. Streaming stops early at the first unfilled slot,
// which the sorter marks with an all-ones value. That value is never emitted.
//
// Parameters
//   WIDTH        bit width of one distance value
//   NUM_OUTPUTS  number of sorted slots in d
//   CNTW         counter width, 2**CNTW must exceed NUM_OUTPUTS
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   d            sorted frame, slot i = d[i*WIDTH +: WIDTH], slot 0 smallest
//   start        one-cycle pulse, d holds a complete frame
//   num_req      number of values requested, sampled on an accepted start
//   start_ready  high while a start would be accepted (IDLE)
//   dout         current value
//   dout_idx     slot index of dout
//   dout_valid   dout/dout_idx valid
//   dout_ready   downstream accepts the beat when high with dout_valid
//   dout_last    final beat of the frame
//   done         one-cycle pulse after a frame completes
//   sent_cnt     number of beats delivered in the last completed frame
// ---------------------------------------------------------------------------
module sorted_stream_out #(
    parameter int WIDTH       = 16,
    parameter int NUM_OUTPUTS = 16,
    parameter int CNTW        = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_OUTPUTS*WIDTH-1:0] d,
    input  logic                         start,
    input  logic [CNTW-1:0]              num_req,
    output logic                         start_ready,
    output logic [WIDTH-1:0]             dout,
    output logic [CNTW-1:0]              dout_idx,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         dout_last,
    output logic                         done,
    output logic [CNTW-1:0]              sent_cnt
);

    localparam logic [WIDTH-1:0] SENTINEL  = '1;
    localparam logic [CNTW-1:0]  NUM_OUT_C = CNTW'(NUM_OUTPUTS);
    localparam logic [CNTW-1:0]  LAST_SLOT = CNTW'(NUM_OUTPUTS - 1);
    localparam logic [CNTW-1:0]  ONE       = CNTW'(1);
    localparam logic [CNTW-1:0]  TWO       = CNTW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] frame_reg [NUM_OUTPUTS];
    logic [WIDTH-1:0] d_slot    [NUM_OUTPUTS];
    // One extra always-clear entry so the look-ahead past the final slot
    // needs no bounds special case.
    logic [NUM_OUTPUTS:0] frame_is_sent;
    logic                 capture;

    logic [CNTW-1:0]  idx_reg,      idx_next;
    logic [CNTW-1:0]  count_reg,    count_next;
    logic [CNTW-1:0]  limit_reg,    limit_next;
    logic [WIDTH-1:0] dout_reg,     dout_next;
    logic [CNTW-1:0]  dout_idx_reg, dout_idx_next;
    logic             dout_valid_reg, dout_valid_next;
    logic             dout_last_reg,  dout_last_next;
    logic             done_reg,     done_next;
    logic [CNTW-1:0]  sent_cnt_reg, sent_cnt_next;

    // Per-slot unpacking and frame storage. Every slot is loaded in parallel
    // on an accepted start, so the frame lives in flops rather than a RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_slot
            assign d_slot[gi]        = d[gi*WIDTH +: WIDTH];
            assign frame_is_sent[gi] = (frame_reg[gi] == SENTINEL);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    frame_reg[gi] <= '0;
                end else if (capture) begin
                    frame_reg[gi] <= d_slot[gi];
                end
            end
        end
    endgenerate

    assign frame_is_sent[NUM_OUTPUTS] = 1'b0;

    // The first beat is loaded straight from d on the accepting edge, so its
    // sentinel checks look at the incoming vector instead of the frame.
    logic d0_sent;
    logic d1_sent;

    assign d0_sent = (d_slot[0] == SENTINEL);

    generate
        if (NUM_OUTPUTS > 1) begin : g_d1
            assign d1_sent = (d_slot[1] == SENTINEL);
        end else begin : g_d1_none
            assign d1_sent = 1'b0;
        end
    endgenerate

    logic [CNTW-1:0] limit_start;
    logic            first_last;

    assign limit_start = (num_req > NUM_OUT_C) ? NUM_OUT_C : num_req;
    assign first_last  = (limit_start == ONE) || d1_sent || (LAST_SLOT == '0);

    // Look-ahead for the beat after the current one: its value, and whether
    // the slot after it is unfilled (which makes it the final beat).
    logic [CNTW-1:0]  nxt_idx;
    logic [CNTW-1:0]  nxt2_idx;
    logic [WIDTH-1:0] frame_nxt_val;
    logic             nxt_sent;
    logic             nxt_last;

    assign nxt_idx  = idx_reg + ONE;
    assign nxt2_idx = idx_reg + TWO;

    always_comb begin
        frame_nxt_val = '0;
        nxt_sent      = 1'b0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (nxt_idx == CNTW'(k)) begin
                frame_nxt_val = frame_reg[k];
            end
        end
        for (int k = 0; k <= NUM_OUTPUTS; k++) begin
            if (nxt2_idx == CNTW'(k)) begin
                nxt_sent = frame_is_sent[k];
            end
        end
    end

    assign nxt_last = (nxt_idx == limit_reg - ONE) || nxt_sent || (nxt_idx == LAST_SLOT);

    // Next-state and datapath logic.
    always_comb begin
        state_next      = state_reg;
        capture         = 1'b0;
        idx_next        = idx_reg;
        count_next      = count_reg;
        limit_next      = limit_reg;
        dout_next       = dout_reg;
        dout_idx_next   = dout_idx_reg;
        dout_valid_next = 1'b0;
        dout_last_next  = 1'b0;
        done_next       = 1'b0;
        sent_cnt_next   = sent_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    limit_next = limit_start;
                    idx_next   = '0;
                    count_next = '0;
                    if ((limit_start == '0) || d0_sent) begin
                        // Nothing to send: finish without emitting a beat.
                        state_next    = DONE;
                        done_next     = 1'b1;
                        sent_cnt_next = '0;
                    end else begin
                        state_next      = SEND;
                        dout_next       = d_slot[0];
                        dout_idx_next   = '0;
                        dout_valid_next = 1'b1;
                        dout_last_next  = first_last;
                    end
                end
            end

            SEND: begin
                // Hold the presented beat until it transfers.
                dout_valid_next = 1'b1;
                dout_last_next  = dout_last_reg;
                if (dout_ready) begin
                    count_next = count_reg + ONE;
                    if (dout_last_reg) begin
                        state_next      = DONE;
                        done_next       = 1'b1;
                        dout_valid_next = 1'b0;
                        dout_last_next  = 1'b0;
                        sent_cnt_next   = count_reg + ONE;
                    end else begin
                        idx_next       = nxt_idx;
                        dout_next      = frame_nxt_val;
                        dout_idx_next  = nxt_idx;
                        dout_last_next = nxt_last;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            count_reg      <= '0;
            limit_reg      <= '0;
            dout_reg       <= '0;
            dout_idx_reg   <= '0;
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
            done_reg       <= 1'b0;
            sent_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            count_reg      <= count_next;
            limit_reg      <= limit_next;
            dout_reg       <= dout_next;
            dout_idx_reg   <= dout_idx_next;
            dout_valid_reg <= dout_valid_next;
            dout_last_reg  <= dout_last_next;
            done_reg       <= done_next;
            sent_cnt_reg   <= sent_cnt_next;
        end
    end

    assign start_ready = (state_reg == IDLE);
    assign dout        = dout_reg;
    assign dout_idx    = dout_idx_reg;
    assign dout_valid  = dout_valid_reg;
    assign dout_last   = dout_last_reg;
    assign done        = done_reg;
    assign sent_cnt    = sent_cnt_reg;

endmodule

// File: tb/tb_sorted_stream_out.sv
// ---------------------------------------------------------------------------
// tb_sorted_stream_out
//
// Drives sorted frames into sorted_stream_out and compares the streamed beats,
// dout_last, done and sent_cnt against a queue-based reference. The reference
// is built directly from the frame contents and the request count.
// ---------------------------------------------------------------------------
module tb_sorted_stream_out;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N*W-1:0] d = '0;
    logic          start = 1'b0;
    logic [CW-1:0] num_req = '0;
    logic          start_ready;
    logic [W-1:0]  dout;
    logic [CW-1:0] dout_idx;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          dout_last;
    logic          done;
    logic [CW-1:0] sent_cnt;

    sorted_stream_out #(
        .WIDTH(W),
        .NUM_OUTPUTS(N),
        .CNTW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .d(d),
        .start(start),
        .num_req(num_req),
        .start_ready(start_ready),
        .dout(dout),
        .dout_idx(dout_idx),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last(dout_last),
        .done(done),
        .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] slots [N];
    logic [W-1:0] exp_q [$];
    int           last_done_cyc;

    // Reference: the first min(nreq, N) slots, cut at the first unfilled one.
    function automatic void model(input int nreq);
        int lim;
        exp_q.delete();
        lim = (nreq > N) ? N : nreq;
        for (int i = 0; i < lim; i++) begin
            if (slots[i] == 16'hFFFF) break;
            exp_q.push_back(slots[i]);
        end
    endfunction

    // Random ascending frame with nvalid filled slots, the rest unfilled.
    task automatic gen_frame(input int nvalid);
        int v;
        v = int'($urandom_range(0, 100));
        for (int k = 0; k < N; k++) begin
            if (k < nvalid) begin
                slots[k] = W'(v);
                v = v + int'($urandom_range(0, 500));
            end else begin
                slots[k] = 16'hFFFF;
            end
        end
    endtask

    // Called at a negedge while the DUT is IDLE; returns at the negedge of
    // the IDLE cycle following done, so calls can be chained back to back.
    // mode 0: ready always 1, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run_frame(input int nreq, input int mode, input bit poke);
        int got, cyc, pc;
        bit prev_stall, saw_done;
        logic r;
        logic [W-1:0]  pv;
        logic [CW-1:0] pi;
        logic          pl;

        model(nreq);
        n_checks++;
        if (start_ready !== 1'b1) $display("FAIL start_ready_idle: got %b expected 1", start_ready);
        else n_pass++;

        for (int k = 0; k < N; k++) d[k*W +: W] = slots[k];
        num_req = CW'(nreq);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        num_req = CW'($urandom_range(0, 31));

        n_checks++;
        if (dout_valid !== (exp_q.size() > 0) || done !== (exp_q.size() == 0))
            $display("FAIL first_cycle: got valid=%b done=%b expected valid=%b done=%b",
                     dout_valid, done, exp_q.size() > 0, exp_q.size() == 0);
        else n_pass++;

        got = 0; pc = 0; cyc = 0;
        prev_stall = 1'b0; saw_done = 1'b0;
        pv = '0; pi = '0; pl = 1'b0;
        while (cyc < 400) begin
            start = 1'b0;
            if (done === 1'b1) begin
                saw_done = 1'b1;
                break;
            end
            n_checks++;
            if (dout_valid !== 1'b1) begin
                $display("FAIL stream_gap: got dout_valid=%b done=%b expected dout_valid=1 at cycle %0d",
                         dout_valid, done, cyc);
                break;
            end else n_pass++;

            if (prev_stall) begin
                n_checks++;
                if (dout !== pv || dout_idx !== pi || dout_last !== pl)
                    $display("FAIL stall_hold: got %0h/%0d/%b expected %0h/%0d/%b",
                             dout, dout_idx, dout_last, pv, pi, pl);
                else n_pass++;
            end

            case (mode)
                0:       r = 1'b1;
                1:       r = (pc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            pc++;

            // A start during SEND carrying a different frame must be ignored.
            if (poke && cyc == 2) begin
                start = 1'b1;
                for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
            end
            dout_ready = r;

            if (r) begin
                n_checks++;
                if (got >= exp_q.size())
                    $display("FAIL extra_beat: got dout=%0h idx=%0d expected no beat", dout, dout_idx);
                else if (dout !== exp_q[got] || dout_idx !== CW'(got) ||
                         dout_last !== 1'(got == exp_q.size() - 1))
                    $display("FAIL beat%0d: got %0h/%0d/%b expected %0h/%0d/%b", got,
                             dout, dout_idx, dout_last, exp_q[got], got, got == exp_q.size() - 1);
                else n_pass++;
                got++;
            end
            prev_stall = !r;
            pv = dout; pi = dout_idx; pl = dout_last;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        last_done_cyc = cyc;

        n_checks++;
        if (saw_done !== 1'b1) $display("FAIL done_seen: got 0 expected 1 within 400 cycles");
        else n_pass++;
        n_checks++;
        if (got != exp_q.size()) $display("FAIL beat_count: got %0d expected %0d", got, exp_q.size());
        else n_pass++;
        n_checks++;
        if (sent_cnt !== CW'(exp_q.size())) $display("FAIL sent_cnt: got %0d expected %0d", sent_cnt, exp_q.size());
        else n_pass++;

        $display("frame nreq=%0d mode=%0d poke=%0d beats=%0d expected=%0d sent_cnt=%0d",
                 nreq, mode, poke, got, exp_q.size(), sent_cnt);

        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL done_one_cycle: got done=%b start_ready=%b expected done=0 start_ready=1", done, start_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        d = {N{16'h1234}};
        num_req = 5'd4;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dout !== '0 || dout_idx !== '0 || dout_valid !== 1'b0 || dout_last !== 1'b0)
            $display("FAIL reset_stream: got %0h/%0d/%b/%b expected 0/0/0/0", dout, dout_idx, dout_valid, dout_last);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0 || sent_cnt !== '0 || start_ready !== 1'b1)
            $display("FAIL reset_status: got done=%b sent_cnt=%0d start_ready=%b expected 0/0/1", done, sent_cnt, start_ready);
        else n_pass++;
        start = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_full_frame();
        for (int k = 0; k < N; k++) slots[k] = W'(k + 1);
        dout_ready = 1'b1;
        run_frame(16, 0, 1'b0);
        n_checks++;
        if (last_done_cyc != 16) $display("FAIL full_throughput: got done after %0d cycles expected 16", last_done_cyc);
        else n_pass++;
        n_checks++;
        if (sent_cnt !== 5'd16) $display("FAIL full_sent_cnt: got %0d expected 16", sent_cnt);
        else n_pass++;
    endtask

    task automatic test_partial();
        slots[0] = 16'd5; slots[1] = 16'd9; slots[2] = 16'd12;
        for (int k = 3; k < N; k++) slots[k] = W'(20 + 3 * k);
        run_frame(3, 0, 1'b0);
        n_checks++;
        if (sent_cnt !== 5'd3) $display("FAIL partial_sent_cnt: got %0d expected 3", sent_cnt);
        else n_pass++;
    endtask

    task automatic test_sentinel_stop();
        for (int k = 0; k < N; k++) slots[k] = (k < 6) ? W'(2 * k + 1) : 16'hFFFF;
        run_frame(10, 0, 1'b0);
        n_checks++;
        if (sent_cnt !== 5'd6) $display("FAIL sentinel_sent_cnt: got %0d expected 6", sent_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        gen_frame(16);
        run_frame(16, 1, 1'b0);
        gen_frame(9);
        run_frame(12, 2, 1'b0);
    endtask

    task automatic test_edge_cases();
        gen_frame(16);
        run_frame(0, 0, 1'b0);
        n_checks++;
        if (sent_cnt !== 5'd0) $display("FAIL zero_req_sent_cnt: got %0d expected 0", sent_cnt);
        else n_pass++;
        run_frame(20, 0, 1'b0);
        n_checks++;
        if (sent_cnt !== 5'd16) $display("FAIL clamp_sent_cnt: got %0d expected 16", sent_cnt);
        else n_pass++;
        gen_frame(0);
        run_frame(5, 0, 1'b0);
        n_checks++;
        if (sent_cnt !== 5'd0) $display("FAIL empty_frame_sent_cnt: got %0d expected 0", sent_cnt);
        else n_pass++;
        gen_frame(16);
        run_frame(16, 1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 12; t++) begin
            gen_frame(int'($urandom_range(0, 16)));
            run_frame(int'($urandom_range(0, 20)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_frame();
        gen_frame(16);
        for (int k = 0; k < N; k++) d[k*W +: W] = slots[k];
        num_req = 5'd16;
        dout_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (dout !== slots[4] || dout_idx !== 5'd4)
            $display("FAIL mid_frame_beat4: got %0h/%0d expected %0h/4", dout, dout_idx, slots[4]);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (dout !== '0 || dout_idx !== '0 || dout_valid !== 1'b0 || dout_last !== 1'b0 ||
            done !== 1'b0 || sent_cnt !== '0 || start_ready !== 1'b1)
            $display("FAIL async_reset: got %0h/%0d/%b/%b/%b/%0d/%b expected 0/0/0/0/0/0/1",
                     dout, dout_idx, dout_valid, dout_last, done, sent_cnt, start_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL reset_abort: got done=%b start_ready=%b expected 0/1", done, start_ready);
        else n_pass++;
        gen_frame(11);
        run_frame(14, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_partial();
        test_sentinel_stop();
        test_backpressure();
        test_edge_cases();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
